// File: rtl/bird_pkg.sv
// Shared definitions for the bird sprite: FSM state codes (common with the
// bird state machine), default screen limits and colour constants.
package bird_pkg;

  localparam logic [3:0] ST_HOLD    = 4'd0;
  localparam logic [3:0] ST_LEFT    = 4'd1;
  localparam logic [3:0] ST_RIGHT   = 4'd2;
  localparam logic [3:0] ST_UP      = 4'd3;
  localparam logic [3:0] ST_DOWN    = 4'd4;
  localparam logic [3:0] ST_CLEAR   = 4'd5;
  localparam logic [3:0] ST_DRAW    = 4'd6;
  localparam logic [3:0] ST_SHOT    = 4'd7;
  localparam logic [3:0] ST_ESCAPE  = 4'd8;
  localparam logic [3:0] ST_CHECK   = 4'd9;
  localparam logic [3:0] ST_PREHOLD = 4'd11;

  localparam int unsigned SCREEN_X_MAX = 159;
  localparam int unsigned SCREEN_Y_MAX = 119;

  localparam logic [2:0] COL_BG   = 3'b011;
  localparam logic [2:0] COL_BIRD = 3'b110;
  localparam logic [2:0] COL_DEAD = 3'b100;

endpackage

// File: rtl/sprite_sweeper.sv
// Row-major pixel sweep over a W x H sprite anchored at (base_x, base_y).
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - holds the pixel counter at 0 (no sweep in progress)
//   active       - sweep this cycle; plot the current pixel and advance
//   base_x/y     - sprite top-left corner
//   vga_x/y      - current pixel coordinate (combinational from counter)
//   plot         - pixel write strobe
//   last         - high while the final pixel is plotted
module sprite_sweeper #(
  parameter int unsigned W = 8,
  parameter int unsigned H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       active,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic       plot,
  output logic       last
);

  localparam int unsigned N  = W * H;
  localparam int unsigned KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  logic [KW-1:0] k;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      k <= '0;
    end else if (active) begin
      k <= last ? '0 : k + KW'(1);
    end
  end

  assign last  = active && (k == K_LAST);
  assign plot  = active;
  assign vga_x = base_x + 8'(32'(k) % W);
  assign vga_y = base_y + 7'(32'(k) / W);

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: owns bird position, ammo and hit detection, sweeps the
// clear/draw pixels into the VGA adapter and returns FSM status flags.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   state             - bird FSM state code (see bird_pkg)
//   trigger           - one-cycle fire pulse
//   cross_x/cross_y   - crosshair position
//   vga_x/vga_y       - pixel coordinate
//   colour, plot      - pixel colour and write strobe
//   enable_draw       - pulse on the last pixel of a sweep
//   shot              - bird hit this round
//   out_of_ammo       - no shots left
//   flying            - bird still on screen
module bird_datapath
  import bird_pkg::*;
#(
  parameter int unsigned START_X   = 76,
  parameter int unsigned START_Y   = 100,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FALL_STEP = 2,
  parameter int unsigned SPRITE_W  = 8,
  parameter int unsigned SPRITE_H  = 8,
  parameter int unsigned AMMO      = 3,
  parameter int unsigned X_MAX     = SCREEN_X_MAX,
  parameter int unsigned Y_MAX     = SCREEN_Y_MAX,
  parameter logic [2:0]  BG_COLOUR   = COL_BG,
  parameter logic [2:0]  BIRD_COLOUR = COL_BIRD,
  parameter logic [2:0]  DEAD_COLOUR = COL_DEAD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic       trigger,
  input  logic [7:0] cross_x,
  input  logic [6:0] cross_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       enable_draw,
  output logic       shot,
  output logic       out_of_ammo,
  output logic       flying
);

  localparam logic [8:0] XL = 9'(X_MAX - SPRITE_W + 1);
  localparam logic [7:0] YL = 8'(Y_MAX - SPRITE_H + 1);
  localparam int unsigned AW = $clog2(AMMO + 1);

  logic [7:0]    bird_x, drawn_x, base_x, x_left, x_right;
  logic [6:0]    bird_y, drawn_y, base_y, y_up, y_down, y_shot;
  logic [8:0]    x_inc, x_hi;
  logic [7:0]    y_inc, y_fall, y_hi;
  logic [AW-1:0] ammo;
  logic          done;
  logic [3:0]    done_state;
  logic          is_draw, sweeping, sweep_last, hit, fire_ok;

  // One spare bit on the increments so clamping never sees a wrapped value.
  assign x_inc   = {1'b0, bird_x} + 9'(STEP);
  assign x_right = (x_inc > XL) ? XL[7:0] : x_inc[7:0];
  assign x_left  = (bird_x < 8'(STEP)) ? '0 : bird_x - 8'(STEP);
  assign y_inc   = {1'b0, bird_y} + 8'(STEP);
  assign y_down  = (y_inc > YL) ? YL[6:0] : y_inc[6:0];
  assign y_up    = (bird_y < 7'(STEP)) ? '0 : bird_y - 7'(STEP);
  assign y_fall  = {1'b0, bird_y} + 8'(FALL_STEP);
  assign y_shot  = (y_fall > YL) ? YL[6:0] : y_fall[6:0];

  assign x_hi = {1'b0, bird_x} + 9'(SPRITE_W - 1);
  assign y_hi = {1'b0, bird_y} + 8'(SPRITE_H - 1);
  assign hit  = (cross_x >= bird_x) && ({1'b0, cross_x} <= x_hi) &&
                (cross_y >= bird_y) && ({1'b0, cross_y} <= y_hi);

  assign fire_ok = trigger && (ammo != '0) && !shot &&
                   !(state inside {ST_PREHOLD, ST_SHOT, ST_ESCAPE, ST_CHECK});

  // done only blocks a re-sweep of the state that just finished, so a
  // CLEAR followed directly by DRAW starts plotting in DRAW's first cycle.
  assign is_draw  = (state == ST_DRAW);
  assign sweeping = ((state == ST_CLEAR) || is_draw) &&
                    !(done && (state == done_state));
  assign base_x   = is_draw ? bird_x : drawn_x;
  assign base_y   = is_draw ? bird_y : drawn_y;
  assign colour   = is_draw ? (shot ? DEAD_COLOUR : BIRD_COLOUR) : BG_COLOUR;

  assign enable_draw = sweep_last;
  assign out_of_ammo = (ammo == '0);

  sprite_sweeper #(.W(SPRITE_W), .H(SPRITE_H)) u_sweeper (
    .clk    (clk),
    .reset  (reset),
    .start  (!sweeping),
    .active (sweeping),
    .base_x (base_x),
    .base_y (base_y),
    .vga_x  (vga_x),
    .vga_y  (vga_y),
    .plot   (plot),
    .last   (sweep_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bird_x     <= 8'(START_X);
      bird_y     <= 7'(START_Y);
      drawn_x    <= 8'(START_X);
      drawn_y    <= 7'(START_Y);
      ammo       <= AW'(AMMO);
      shot       <= 1'b0;
      flying     <= 1'b1;
      done       <= 1'b0;
      done_state <= ST_HOLD;
    end else begin
      case (state)
        ST_LEFT:  bird_x <= x_left;
        ST_RIGHT: bird_x <= x_right;
        ST_UP:    bird_y <= y_up;
        ST_DOWN:  bird_y <= y_down;
        ST_SHOT: begin
          bird_y <= y_shot;
          flying <= (y_shot != YL[6:0]);
        end
        ST_ESCAPE: begin
          bird_y <= y_up;
          flying <= (y_up != '0);
        end
        ST_PREHOLD: begin
          // drawn_x/drawn_y keep the old sprite so the next CLEAR erases it
          bird_x <= 8'(START_X);
          bird_y <= 7'(START_Y);
          ammo   <= AW'(AMMO);
          flying <= 1'b1;
        end
        default: ;
      endcase

      if (state == ST_PREHOLD) begin
        shot <= 1'b0;
      end else if (fire_ok) begin
        ammo <= ammo - AW'(1);
        if (hit) shot <= 1'b1;
      end

      if (sweep_last) begin
        done       <= 1'b1;
        done_state <= state;
        if (is_draw) begin
          drawn_x <= bird_x;
          drawn_y <= bird_y;
        end
      end else if (state != done_state) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bird_datapath.sv
module tb_bird_datapath;
  import bird_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic       trigger;
  logic [7:0] cross_x;
  logic [6:0] cross_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, enable_draw, shot, out_of_ammo, flying;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } pix_t;

  pix_t sb[$];

  bird_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .trigger     (trigger),
    .cross_x     (cross_x),
    .cross_y     (cross_y),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .colour      (colour),
    .plot        (plot),
    .enable_draw (enable_draw),
    .shot        (shot),
    .out_of_ammo (out_of_ammo),
    .flying      (flying)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge; inputs change here,
  // outputs are sampled 3 units later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic hold_state(input logic [3:0] st, input int n);
    state = st;
    repeat (n) tick();
    state = ST_HOLD;
  endtask

  // Push the expected pixel stream, then pop one entry per plotted pixel.
  task automatic run_sweep(input string nm, input logic [3:0] st,
                           input logic [7:0] bx, input logic [6:0] by,
                           input logic [2:0] col);
    pix_t e;
    pix_t got;
    int   cyc;
    for (int k = 0; k < 64; k++) begin
      e.x    = bx + 8'(k % 8);
      e.y    = by + 7'(k / 8);
      e.c    = col;
      e.last = (k == 63);
      sb.push_back(e);
    end
    state = st;
    cyc   = 0;
    while (sb.size() > 0 && cyc < 80) begin
      #3;
      e   = sb.pop_front();
      got = '{vga_x, vga_y, colour, enable_draw};
      checks++;
      if (!plot || got !== e) begin
        errors++;
        $display("FAIL %s pixel %0d: got plot=%b x=%0d y=%0d c=%b en=%b, expected plot=1 x=%0d y=%0d c=%b en=%b",
                 nm, cyc, plot, vga_x, vga_y, colour, enable_draw, e.x, e.y, e.c, e.last);
      end
      tick();
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d pixels outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
    #3;
    checks++;
    if (plot !== 1'b0 || enable_draw !== 1'b0) begin
      errors++;
      $display("FAIL %s after sweep: plot=%b en=%b, expected 0 0", nm, plot, enable_draw);
    end
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; state = ST_HOLD; trigger = 1'b0; cross_x = '0; cross_y = '0;
    tick(); tick();
    #3;
    checks++;
    if ({plot, enable_draw, shot, out_of_ammo, flying} !== 5'b00001) begin
      errors++;
      $display("FAIL reset flags: plot=%b en=%b shot=%b ooa=%b fly=%b, expected 0 0 0 0 1",
               plot, enable_draw, shot, out_of_ammo, flying);
    end
    checks++;
    if (dut.bird_x !== 8'd76 || dut.bird_y !== 7'd100 || dut.ammo !== 2'd3) begin
      errors++;
      $display("FAIL reset regs: x=%0d y=%0d ammo=%0d, expected 76 100 3",
               dut.bird_x, dut.bird_y, dut.ammo);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_moves;
    hold_state(ST_LEFT, 80);
    #3;
    checks++;
    if (dut.bird_x !== 8'd0) begin
      errors++; $display("FAIL left clamp: x=%0d, expected 0", dut.bird_x);
    end
    tick();
    hold_state(ST_LEFT, 1);
    #3;
    checks++;
    if (dut.bird_x !== 8'd0) begin
      errors++; $display("FAIL left at 0: x=%0d, expected 0", dut.bird_x);
    end
    tick();
    hold_state(ST_RIGHT, 160);
    #3;
    checks++;
    if (dut.bird_x !== 8'd152) begin
      errors++; $display("FAIL right clamp: x=%0d, expected 152", dut.bird_x);
    end
    tick();
    hold_state(ST_DOWN, 10);
    #3;
    checks++;
    if (dut.bird_y !== 7'd110) begin
      errors++; $display("FAIL down x10: y=%0d, expected 110", dut.bird_y);
    end
    tick();
    run_sweep("draw_moved", ST_DRAW, 8'd152, 7'd110, 3'b110);
    state = ST_HOLD;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_hit;
    cross_x = 8'd80; cross_y = 7'd104; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    #3;
    checks++;
    if (shot !== 1'b1 || dut.ammo !== 2'd2 || out_of_ammo !== 1'b0) begin
      errors++;
      $display("FAIL hit: shot=%b ammo=%0d ooa=%b, expected 1 2 0", shot, dut.ammo, out_of_ammo);
    end
    tick();
    run_sweep("draw_dead", ST_DRAW, 8'd76, 7'd100, 3'b100);
    state = ST_HOLD;
  endtask

  task automatic test_fall;
    hold_state(ST_DOWN, 8);
    hold_state(ST_SHOT, 1);
    #3;
    checks++;
    if (dut.bird_y !== 7'd110 || flying !== 1'b1) begin
      errors++; $display("FAIL fall 1: y=%0d fly=%b, expected 110 1", dut.bird_y, flying);
    end
    tick();
    hold_state(ST_SHOT, 1);
    #3;
    checks++;
    if (dut.bird_y !== 7'd112 || flying !== 1'b0) begin
      errors++; $display("FAIL fall 2: y=%0d fly=%b, expected 112 0", dut.bird_y, flying);
    end
    tick();
    hold_state(ST_CHECK, 1);
    #3;
    checks++;
    if (dut.bird_y !== 7'd112 || flying !== 1'b0 || shot !== 1'b1) begin
      errors++; $display("FAIL check hold: y=%0d fly=%b shot=%b, expected 112 0 1", dut.bird_y, flying, shot);
    end
    tick();
    run_sweep("draw_fallen", ST_DRAW, 8'd76, 7'd112, 3'b100);
    hold_state(ST_PREHOLD, 1);
    #3;
    checks++;
    if (shot !== 1'b0 || flying !== 1'b1 || dut.bird_x !== 8'd76 ||
        dut.bird_y !== 7'd100 || dut.ammo !== 2'd3) begin
      errors++;
      $display("FAIL prehold: shot=%b fly=%b x=%0d y=%0d ammo=%0d, expected 0 1 76 100 3",
               shot, flying, dut.bird_x, dut.bird_y, dut.ammo);
    end
    tick();
    // The erase must target the last drawn position, not the new start.
    run_sweep("clear_old", ST_CLEAR, 8'd76, 7'd112, 3'b011);
    state = ST_HOLD;
  endtask

  task automatic test_ammo;
    state = ST_CHECK; cross_x = 8'd80; cross_y = 7'd104; trigger = 1'b1;
    tick();
    trigger = 1'b0; state = ST_HOLD;
    #3;
    checks++;
    if (dut.ammo !== 2'd3 || shot !== 1'b0) begin
      errors++; $display("FAIL trigger in check: ammo=%0d shot=%b, expected 3 0", dut.ammo, shot);
    end
    tick();
    cross_x = 8'd0; cross_y = 7'd0;
    for (int i = 1; i <= 4; i++) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      #3;
      checks++;
      if (out_of_ammo !== (i >= 3) || dut.ammo !== 2'((i >= 3) ? 0 : 3 - i) || shot !== 1'b0) begin
        errors++;
        $display("FAIL miss %0d: ooa=%b ammo=%0d shot=%b, expected %b %0d 0",
                 i, out_of_ammo, dut.ammo, shot, (i >= 3), (i >= 3) ? 0 : 3 - i);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep;
    hold_state(ST_LEFT, 5);
    state = ST_DRAW;
    repeat (20) tick();
    #3;
    checks++;
    if (plot !== 1'b1 || vga_x !== 8'd75 || vga_y !== 7'd102) begin
      errors++;
      $display("FAIL pixel 20: plot=%b x=%0d y=%0d, expected 1 75 102", plot, vga_x, vga_y);
    end
    reset = 1'b1; state = ST_HOLD;
    tick();
    reset = 1'b0;
    #3;
    checks++;
    if (plot !== 1'b0 || dut.bird_x !== 8'd76 || dut.ammo !== 2'd3) begin
      errors++;
      $display("FAIL reset mid sweep: plot=%b x=%0d ammo=%0d, expected 0 76 3", plot, dut.bird_x, dut.ammo);
    end
    tick();
    run_sweep("draw_after_reset", ST_DRAW, 8'd76, 7'd100, 3'b110);
    hold_state(ST_PREHOLD, 1);
    #3;
    checks++;
    if (shot !== 1'b0 || flying !== 1'b1) begin
      errors++; $display("FAIL prehold after reset: shot=%b fly=%b, expected 0 1", shot, flying);
    end
    tick();
  endtask

  initial begin
    test_reset();
    run_sweep("clear_reset", ST_CLEAR, 8'd76, 7'd100, 3'b011);
    // back-to-back CLEAR then DRAW must restart at pixel 0
    run_sweep("draw_b2b", ST_DRAW, 8'd76, 7'd100, 3'b110);
    state = ST_HOLD;
    tick();
    test_moves();
    test_hit();
    test_fall();
    test_ammo();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bird_datapath.md
Name: bird_datapath

Overview:
- Datapath companion to the bird state machine; sits directly downstream of it.
- Consumes the 4-bit bird STATE code and owns bird position, ammo and hit detection.
- Sweeps clear/draw pixels for the bird sprite into the VGA adapter.
- Returns the status inputs the FSM branches on: enableDraw, shot, outOfAmmo, flying.

Parameters:
- START_X, 76, bird x at reset / new round
- START_Y, 100, bird y at reset / new round
- STEP, 1, pixels per LEFT/RIGHT/UP/DOWN/ESCAPE move
- FALL_STEP, 2, pixels per SHOT (falling) move
- SPRITE_W, 8, sprite width in pixels
- SPRITE_H, 8, sprite height in pixels
- AMMO, 3, shots per round
- X_MAX, 159, last screen column
- Y_MAX, 119, last screen row
- BG_COLOUR, 3'b011, clear colour
- BIRD_COLOUR, 3'b110, live bird colour
- DEAD_COLOUR, 3'b100, shot bird colour

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset (one clock, all state on rising clk)
- state  in  4  bird FSM state code
- trigger  in  1  one-cycle player fire pulse
- cross_x  in  8  crosshair column
- cross_y  in  7  crosshair row
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- enable_draw  out  1  sweep-complete pulse (FSM enableDraw)
- shot  out  1  bird hit this round
- out_of_ammo  out  1  ammo count == 0
- flying  out  1  bird still on screen

Behaviour:
- State codes: HOLD 0, LEFT 1, RIGHT 2, UP 3, DOWN 4, CLEAR 5, DRAW 6, SHOT 7, ESCAPE 8, CHECK 9, PREHOLD 11. Codes 10, 12-15: no action.
- Reset values:
  - bird_x=START_X, bird_y=START_Y; drawn_x/drawn_y = same.
  - ammo=AMMO, shot=0, flying=1, sweep counter=0, done=0.
  - plot=0, enable_draw=0.
- Limits: XL = X_MAX-SPRITE_W+1 (152), YL = Y_MAX-SPRITE_H+1 (112).
- Moves (applied every cycle the state is present; FSM holds move states one cycle):
  - LEFT: x = (x<STEP) ? 0 : x-STEP.
  - RIGHT: x = min(x+STEP, XL).
  - UP and DOWN: same rules on y with YL.
- SHOT: y_next = min(y+FALL_STEP, YL); flying <= (y_next != YL). Registered in the same edge as the move.
- ESCAPE: y_next = (y<STEP) ? 0 : y-STEP; flying <= (y_next != 0).
- CHECK: no register change.
- PREHOLD, every cycle: x=START_X, y=START_Y, ammo=AMMO, shot=0, flying=1. drawn_x/drawn_y are NOT reset, so the next CLEAR erases the old sprite.
- Fire:
  - A trigger is accepted only when state ∉ {PREHOLD, SHOT, ESCAPE, CHECK}, ammo>0 and shot=0.
  - Accepted trigger: ammo decrements.
  - Hit test is against registered bird_x/bird_y: cross_x ∈ [bird_x, bird_x+SPRITE_W-1] and cross_y ∈ [bird_y, bird_y+SPRITE_H-1]. Hit sets shot=1.
  - Hit on the last round sets both shot and out_of_ammo; the FSM gives shot priority.
  - A trigger with ammo=0 is ignored.
- Sweep (CLEAR or DRAW, done=0):
  - Counter k runs 0..SPRITE_W*SPRITE_H-1, row-major.
  - Outputs combinational from counter: plot=1, vga_x=base_x+k%W, vga_y=base_y+k/W.
  - CLEAR: base = drawn_x/drawn_y, colour=BG_COLOUR.
  - DRAW: base = bird_x/bird_y, colour = shot ? DEAD_COLOUR : BIRD_COLOUR. drawn_x/drawn_y <= bird_x/bird_y on the last pixel.
  - Pixel k is plotted in the k-th cycle of the state (cycle 0 = first cycle state is visible).
  - enable_draw=1 only in the last-pixel cycle (cycle 63 at defaults). At that edge the counter wraps to 0 and done=1.
  - done clears when state is no longer the one being swept, so CLEAR→DRAW restarts cleanly at k=0.
  - Outside a sweep: plot=0, enable_draw=0, counter held at 0.
- Reset asserted mid-sweep: plot drops the next cycle; all registers take reset values.
- Arithmetic width: one extra bit for x+STEP and y+FALL_STEP before clamping; no wrap-around is permitted.

Decomposition:
- Shared package bird_pkg: the 4-bit state localparams (shared with the FSM), screen limits, colour constants.
- One sub-module, sprite_sweeper:
  - Inputs: base_x/base_y, start/active.
  - Outputs: vga_x, vga_y, plot, last.
  - Reused later by the dog and crosshair drawers.

Test Plan:
- Reset, hold state=5 (CLEAR): plot high 64 cycles.
  - First pixel (76,100), last pixel (83,107), colour 3'b011.
  - enable_draw high only on cycle 63; then plot=0.
- State=1 with x=0 → x stays 0. State=2 with x=152 → x stays 152. State=4 ten times from y=100 → y=110.
- Crosshair (80,104), trigger in HOLD → shot=1, ammo=2. Next DRAW uses colour 3'b100.
- Three misses at (0,0) → out_of_ammo=1 after the third. Fourth trigger ignored, ammo stays 0.
- shot=1, y=108, state=7 → y=110, flying=1. Again → y=112, flying=0 registered before CHECK.
- Reset asserted at sweep pixel 20 → plot=0 next cycle, bird_x=76, ammo=3. State=11 → shot=0, flying=1.
